// File: rtl/dm_pkg.sv
// dm_pkg: shared encodings for the data-memory controller
// Provides SIZE_B/SIZE_H/SIZE_W access sizes, FSM state type and latency counter width.
package dm_pkg;
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam int LAT_W = 3;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;
endpackage

// File: rtl/dm_lane_align.sv
// dm_lane_align: store lane merge, load extract/extend and alignment check
// Ports: size/addr/wdata/rword/sign in; be (lane mask), wword (merged word),
// rdata_ext (extended load data), misalign (bad alignment or illegal size) out.
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  input  logic        sign,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata_ext,
  output logic        misalign
);
  logic [31:0] wlane;
  logic [7:0]  b;
  logic [15:0] h;
  assign misalign = size == 2'b11 || (size == SIZE_H && addr[0]) || (size == SIZE_W && addr != 2'b00);
  assign be = size == SIZE_B ? 4'b0001 << addr : size == SIZE_H ? 4'b0011 << {addr[1], 1'b0} : 4'b1111;
  assign wlane = size == SIZE_B ? {4{wdata[7:0]}} : size == SIZE_H ? {2{wdata[15:0]}} : wdata;
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign wword[8*i +: 8] = be[i] ? wlane[8*i +: 8] : rword[8*i +: 8];
  end
  assign b = 8'(rword >> {addr, 3'b000});
  assign h = 16'(rword >> {addr[1], 4'b0000});
  assign rdata_ext = size == SIZE_B ? {{24{sign & b[7]}}, b} : size == SIZE_H ? {{16{sign & h[15]}}, h} : rword;
endmodule

// File: rtl/dm_ctrl.sv
// dm_ctrl: MEM-stage data memory with sized stores, extended loads and valid/ready handshake
// Ports: clk, reset (sync, active-high); req_valid/req_ready/req_we/req_size/req_sign/
// req_addr/req_wdata/req_pc request side; rsp_valid/rsp_ready/rsp_rdata/rsp_err response side.
// Define DM_TRACE_EN to print every committed store.
module dm_ctrl
  import dm_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int DEPTH = 2 ** (ADDR_W - 2);
  logic [31:0] mem [DEPTH];
  state_t state, nxt;
  logic [LAT_W-1:0] cnt;
  logic lat_we, lat_sign, cur_we, cur_sign, acc, done, misalign;
  logic [1:0] lat_size, cur_size;
  logic [ADDR_W-1:0] lat_addr, cur_addr;
  logic [3:0] be;
  logic [31:0] wword, rdata_ext;
  logic unused_ok;
  // In IDLE the live request drives the datapath so the accept edge can commit
  // stores and, at LATENCY=1, capture load data; afterwards the latched copy does.
  assign cur_we   = state == S_IDLE ? req_we : lat_we;
  assign cur_sign = state == S_IDLE ? req_sign : lat_sign;
  assign cur_size = state == S_IDLE ? req_size : lat_size;
  assign cur_addr = state == S_IDLE ? req_addr[ADDR_W-1:0] : lat_addr;
  assign acc  = state == S_IDLE && req_valid;
  assign done = (acc && LATENCY == 1) || (state == S_WAIT && cnt == LAT_W'(1));
  assign nxt  = done ? S_RESP : acc ? S_WAIT : (state == S_RESP && rsp_ready) ? S_IDLE : state;
  assign unused_ok = ^{req_pc, req_addr[31:ADDR_W], be};
  dm_lane_align u_align (
    .size     (cur_size),
    .addr     (cur_addr[1:0]),
    .wdata    (req_wdata),
    .rword    (mem[cur_addr[ADDR_W-1:2]]),
    .sign     (cur_sign),
    .be       (be),
    .wword    (wword),
    .rdata_ext(rdata_ext),
    .misalign (misalign)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_sign  <= 1'b0;
      lat_size  <= '0;
      lat_addr  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state     <= nxt;
      req_ready <= nxt == S_IDLE;
      cnt       <= acc ? LAT_W'(LATENCY - 1) : cnt - LAT_W'(state == S_WAIT);
      if (acc) begin
        lat_we   <= req_we;
        lat_sign <= req_sign;
        lat_size <= req_size;
        lat_addr <= req_addr[ADDR_W-1:0];
        if (req_we && !misalign) begin
          mem[cur_addr[ADDR_W-1:2]] <= wword;
`ifdef DM_TRACE_EN
          $display("%d@%h: *%h <= %h", $time, req_pc, {req_addr[31:2], 2'b00}, wword);
`endif
        end
      end
      if (done) begin
        rsp_valid <= 1'b1;
        rsp_err   <= misalign;
        rsp_rdata <= (cur_we || misalign) ? '0 : rdata_ext;
      end else if (state == S_RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end
endmodule
